// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges pipeline, multiplier and FPU results onto the single register-file write port.
// Long-latency results queue per source and drain in idle slots; busy mask and stall request guard hazards.
module writeback_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        RegWriteW,
    input  logic [3:0]  WA3W,
    input  logic [31:0] ResultW,
    input  logic        MvalidM,
    input  logic [3:0]  MdestM,
    input  logic [31:0] MresultM,
    output logic        Mready,
    input  logic        FvalidF,
    input  logic [3:0]  FdestF,
    input  logic [31:0] FresultF,
    output logic        Fready,
    output logic        WE3,
    output logic [3:0]  A3,
    output logic [31:0] WD3,
    output logic [14:0] BusyMask,
    output logic        StallReq,
    output logic        DropErr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [3:0]    m_dest [DEPTH];
    logic [31:0]   m_data [DEPTH];
    logic [3:0]    f_dest [DEPTH];
    logic [31:0]   f_data [DEPTH];
    logic [AW-1:0] m_wr, m_rd, f_wr, f_rd;
    logic [CW-1:0] m_cnt, f_cnt;
    logic          last_f;
    logic [SW-1:0] starve;
    logic          drop_err;
    logic          m_ne, f_ne, m_acc, f_acc, m_push, f_push, gnt_m, gnt_f;

    always_comb begin
        m_ne   = m_cnt != '0;
        f_ne   = f_cnt != '0;
        Mready = !RESET && (m_cnt != CW'(DEPTH));
        Fready = !RESET && (f_cnt != CW'(DEPTH));
        m_acc  = MvalidM && Mready;
        f_acc  = FvalidF && Fready;
        m_push = m_acc && (MdestM != 4'hF);
        f_push = f_acc && (FdestF != 4'hF);
        // On contention the source not granted last time wins
        gnt_m  = !RESET && !RegWriteW && m_ne && (!f_ne || last_f);
        gnt_f  = !RESET && !RegWriteW && f_ne && !gnt_m;
        WE3    = !RESET && (RegWriteW || m_ne || f_ne);
        A3     = RESET ? 4'd0 : RegWriteW ? WA3W : gnt_m ? m_dest[m_rd] : gnt_f ? f_dest[f_rd] : 4'd0;
        WD3    = RESET ? 32'd0 : RegWriteW ? ResultW : gnt_m ? m_data[m_rd] : gnt_f ? f_data[f_rd] : 32'd0;
        StallReq = starve == SW'(STARVE_LIMIT);
        DropErr  = drop_err;
    end

    always_comb begin
        BusyMask = '0;
        for (int r = 0; r < 15; r++)
            for (int i = 0; i < DEPTH; i++)
                if (!RESET && ((CW'(i) < m_cnt && m_dest[m_rd + AW'(i)] == 4'(r)) ||
                               (CW'(i) < f_cnt && f_dest[f_rd + AW'(i)] == 4'(r))))
                    BusyMask[r] = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            m_wr     <= '0;
            m_rd     <= '0;
            m_cnt    <= '0;
            f_wr     <= '0;
            f_rd     <= '0;
            f_cnt    <= '0;
            last_f   <= 1'b1;
            starve   <= '0;
            drop_err <= 1'b0;
        end else begin
            m_wr     <= m_wr + AW'(m_push);
            m_rd     <= m_rd + AW'(gnt_m);
            m_cnt    <= m_cnt + CW'(m_push) - CW'(gnt_m);
            f_wr     <= f_wr + AW'(f_push);
            f_rd     <= f_rd + AW'(gnt_f);
            f_cnt    <= f_cnt + CW'(f_push) - CW'(gnt_f);
            if (gnt_m || gnt_f)
                last_f <= gnt_f;
            starve   <= (gnt_m || gnt_f) ? '0 :
                        ((m_ne || f_ne) && RegWriteW && starve != SW'(STARVE_LIMIT)) ? starve + 1'b1 : starve;
            drop_err <= (m_acc && MdestM == 4'hF) || (f_acc && FdestF == 4'hF);
        end
    end

    always_ff @(posedge CLK) begin
        if (m_push) begin
            m_dest[m_wr] <= MdestM;
            m_data[m_wr] <= MresultM;
        end
        if (f_push) begin
            f_dest[f_wr] <= FdestF;
            f_data[f_wr] <= FresultF;
        end
    end
endmodule
